// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// legal WIDTH bounds.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), one bit per clock.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_subtractor: WIDTH out of legal range");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;
  logic             diff_bit_d;
  logic             br_d;

  full_subtractor_cell u_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (diff_bit_d),
    .bo (br_d)
  );

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // br_q still holds the borrow into the MSB during the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == SHIFT && cnt_q == CNT_W'(WIDTH - 1)) begin
      ovf_q <= br_q ^ br_d;
    end
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            diff_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          bout_q <= br_d;
          diff_q <= {diff_bit_d, diff_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); directed and random
// operations compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; poke >= 0 re-pulses start (with a=0x77) on that
  // SHIFT cycle index to confirm it is ignored.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic tbin, input int poke, input string tag);
    logic [W:0]   full;
    logic [W-1:0] ed;
    logic         eb;
    int           lat;
    int           bcnt;
    int           sd;
    full = {1'b0, ta} - {1'b0, tbv} - (W+1)'(tbin);
    ed   = full[W-1:0];
    eb   = full[W];
    sd   = int'($signed(ta)) - int'($signed(tbv)) - int'(tbin);
    @(negedge clk);
    a = ta; b = tbv; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (lat == poke) begin a = 8'h77; start = 1'b1; end
      if (lat == poke + 1) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    $display("op %s: a=0x%02h b=0x%02h bin=%0d -> diff=0x%02h bout=%0d lat=%0d",
             tag, ta, tbv, tbin, diff, bout, lat);
    check({tag, ".latency"}, 64'(lat), 64'(W));
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'(W));
    check({tag, ".diff"}, 64'(diff), 64'(ed));
    check({tag, ".bout"}, 64'(bout), 64'(eb));
    check({tag, ".busy_at_done"}, 64'(busy), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, ".ovf"}, 64'(ovf), 64'((sd < -128 || sd > 127) ? 1 : 0));
`endif
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(done), 64'(0));
    check({tag, ".diff_held"}, 64'(diff), 64'(ed));
  endtask

  initial begin
    int t1, t2, k;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.diff", 64'(diff), 64'(0));
    check("rst.bout", 64'(bout), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
    check("rst.ovf", 64'(ovf), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, -1, "d05m03");
    do_op(8'h03, 8'h05, 1'b0, -1, "d03m05");
    do_op(8'h00, 8'h00, 1'b1, -1, "d00m00b");
    do_op(8'hFF, 8'hFF, 1'b0, -1, "dFFmFF");
    do_op(8'h10, 8'h01, 1'b0, 2, "ignore_start");

    // start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; bin = 1'b0; start = 1'b1;
    k = 0;
    @(posedge clk); #1;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    t1 = cyc;
    check("held.diff1", 64'(diff), 64'(0));
    @(posedge clk); #1;
    k = 0;
    while (!done && k < 40) begin @(posedge clk); #1; k++; end
    t2 = cyc;
    start = 1'b0;
    $display("held start: done at cycles %0d and %0d", t1, t2);
    check("held.period", 64'(t2 - t1), 64'(W + 2));
    check("held.diff2", 64'(diff), 64'(0));
    repeat (2) @(posedge clk);

    // Reset on the 4th SHIFT cycle aborts at once.
    @(negedge clk);
    a = 8'hC3; b = 8'h21; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-op reset: busy=%0d done=%0d diff=0x%02h bout=%0d", busy, done, diff, bout);
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.done", 64'(done), 64'(0));
    check("abort.diff", 64'(diff), 64'(0));
    check("abort.bout", 64'(bout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort.idle_busy", 64'(busy), 64'(0));
    check("abort.idle_done", 64'(done), 64'(0));
    do_op(8'h09, 8'h04, 1'b0, -1, "after_reset");

`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, 1'b0, -1, "ovf_80m01");
    do_op(8'h7F, 8'hFF, 1'b0, -1, "ovf_7FmFF");
    do_op(8'h05, 8'h03, 1'b0, -1, "ovf_05m03");
`endif

    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
